// File: rtl/avg_fifo.sv
// avg_fifo: buffers 10-bit accumulated sums from the 4-sample accumulator in a
// DEPTH-entry FIFO and presents the per-sample average (sum / 4) as an 8-bit
// value on a second valid/ready handshake.
//
// Build option: define AVG_FIFO_ROUND_EN for round-half-up averaging with
// saturation to 255; leave it undefined for plain truncation.
//
// Neither ready_a nor valid_b has a combinational path from the handshake
// inputs. Both depend only on the registered level, so a full FIFO never
// writes through in the same cycle that it is read.

module avg_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_a,
    input  logic [9:0]               data_in,
    output logic                     ready_a,
    output logic                     valid_b,
    input  logic                     ready_b,
    output logic [7:0]               data_out,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Storage and bookkeeping state.
    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic          w_wr_en;
    logic          w_rd_en;
    logic [9:0]    w_head;

    // Handshake flags come only from registered state.
    assign ready_a = (r_level != LW'(DEPTH));
    assign valid_b = (r_level != '0);
    assign level   = r_level;

    assign w_wr_en = valid_a & ready_a;
    assign w_rd_en = valid_b & ready_b;

    // The head entry is read straight from the array. It therefore stays stable
    // while the consumer stalls, and a new write never bypasses onto data_out.
    assign w_head  = r_mem[r_rd_ptr];

`ifdef AVG_FIFO_ROUND_EN
    logic [10:0] w_rounded;
    logic [8:0]  w_quot;

    // Round half up: add half of the divisor, then divide by 4 and clamp to 8 bits.
    assign w_rounded = {1'b0, w_head} + 11'd2;
    assign w_quot    = 9'(w_rounded >> 2);
    assign data_out  = (w_quot > 9'd255) ? 8'hFF : w_quot[7:0];
`else
    // Truncating divide by 4. A 10-bit sum shifted right by two always fits in 8 bits.
    assign data_out  = 8'(w_head >> 2);
`endif

    // Capture an accepted sum into the slot at the write pointer.
    // NOTE: the storage array has no reset. Its contents are don't-care while
    // level is 0, and leaving them unreset lets the array map onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Advance the pointers on each accepted transfer. They wrap modulo DEPTH
    // because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // updates from the values that held before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Track occupancy. A simultaneous read and write leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_avg_fifo.sv
// Directed testbench for avg_fifo (DEPTH = 4). Expected values are computed by hand.
module tb_avg_fifo;

    logic       clk;
    logic       rst_n;
    logic       valid_a;
    logic [9:0] data_in;
    logic       ready_a;
    logic       valid_b;
    logic       ready_b;
    logic [7:0] data_out;
    logic [2:0] level;

    int n_checks = 0;
    int n_errors = 0;

    avg_fifo #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_a  (valid_a),
        .data_in  (data_in),
        .ready_a  (ready_a),
        .valid_b  (valid_b),
        .ready_b  (ready_b),
        .data_out (data_out),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock. Outputs are then sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int lvl, input int ra, input int vb);
        chk({tag, ".level"},   int'(level),   lvl);
        chk({tag, ".ready_a"}, int'(ready_a), ra);
        chk({tag, ".valid_b"}, int'(valid_b), vb);
    endtask

    initial begin
        int exp_r0, exp_r1, exp_r2, exp_r3;

        // ---- reset ----
        rst_n   = 1'b0;
        valid_a = 1'b0;
        data_in = '0;
        ready_b = 1'b0;
        #12;
        chk_state("reset", 0, 1, 0);
        rst_n = 1'b1;
        tick();

        // ---- single write: 400 -> 100, one cycle latency ----
        valid_a = 1'b1; data_in = 10'd400; ready_b = 1'b1;
        chk("single.pre_valid_b", int'(valid_b), 0);
        tick();
        valid_a = 1'b0;
        chk_state("single.after_wr", 1, 1, 1);
        chk("single.data_out", int'(data_out), 100);
        tick();
        chk_state("single.after_rd", 0, 1, 0);

        // ---- fill with ready_b low, 5th held ----
        ready_b = 1'b0;
        valid_a = 1'b1;
        data_in = 10'd4;  tick();
        data_in = 10'd8;  tick();
        data_in = 10'd12; tick();
        data_in = 10'd16; tick();
        chk_state("fill.full", 4, 0, 1);
        chk("fill.head", int'(data_out), 1);
        data_in = 10'd20;            // held by upstream while ready_a is low
        tick();
        chk_state("fill.held", 4, 0, 1);
        chk("fill.head_held", int'(data_out), 1);
        ready_b = 1'b1;              // full and read in the same cycle: no write-through
        chk("fill.ready_a_full_rd", int'(ready_a), 0);
        tick();
        chk_state("drain.1", 3, 1, 1);
        chk("drain.out2", int'(data_out), 2);
        tick();                      // read 8, write the held 20
        valid_a = 1'b0;
        chk_state("drain.2", 3, 1, 1);
        chk("drain.out3", int'(data_out), 3);
        tick();
        chk("drain.out4", int'(data_out), 4);
        chk("drain.lvl2", int'(level), 2);
        tick();
        chk("drain.out5", int'(data_out), 5);
        chk("drain.lvl1", int'(level), 1);
        tick();
        chk_state("drain.empty", 0, 1, 0);

        // ---- steady state at level 2 with simultaneous read/write, across wraps ----
        ready_b = 1'b0;
        valid_a = 1'b1;
        data_in = 10'd40; tick();
        data_in = 10'd44; tick();
        ready_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data_in = 10'(48 + 4 * k);
            chk($sformatf("stream.level[%0d]", k), int'(level), 2);
            chk($sformatf("stream.out[%0d]", k), int'(data_out), 10 + k);
            tick();
        end
        valid_a = 1'b0;
        chk("stream.out_tail0", int'(data_out), 20);
        chk("stream.level_tail", int'(level), 2);
        tick();
        chk("stream.out_tail1", int'(data_out), 21);
        tick();
        chk_state("stream.empty", 0, 1, 0);

        // ---- averaging arithmetic: 6, 5, 1023, 1022 ----
`ifdef AVG_FIFO_ROUND_EN
        exp_r0 = 2; exp_r1 = 1; exp_r2 = 255; exp_r3 = 255;
`else
        exp_r0 = 1; exp_r1 = 1; exp_r2 = 255; exp_r3 = 255;
`endif
        ready_b = 1'b0;
        valid_a = 1'b1;
        data_in = 10'd6;    tick();
        data_in = 10'd5;    tick();
        data_in = 10'd1023; tick();
        data_in = 10'd1022; tick();
        valid_a = 1'b0;
        ready_b = 1'b1;
        chk("avg.6",    int'(data_out), exp_r0); tick();
        chk("avg.5",    int'(data_out), exp_r1); tick();
        chk("avg.1023", int'(data_out), exp_r2); tick();
        chk("avg.1022", int'(data_out), exp_r3); tick();
        chk_state("avg.empty", 0, 1, 0);

        // ---- asynchronous reset at level 3 ----
        ready_b = 1'b0;
        valid_a = 1'b1;
        data_in = 10'd100; tick();
        data_in = 10'd200; tick();
        data_in = 10'd300; tick();
        chk("rst.pre_level", int'(level), 3);
        ready_b = 1'b1;
        #1 rst_n = 1'b0;             // between edges: must act immediately
        #1;
        chk_state("rst.async", 0, 1, 0);
        #1 rst_n = 1'b1;
        data_in = 10'd800;
        ready_b = 1'b0;
        tick();
        valid_a = 1'b0;
        chk_state("rst.sole", 1, 1, 1);
        chk("rst.sole_out", int'(data_out), 200);
        tick();
        chk("rst.sole_hold", int'(level), 1);
        ready_b = 1'b1;
        tick();
        chk_state("rst.drained", 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/avg_fifo.md
# avg_fifo

Downstream consumer of the 4-sample accumulator stage: accepts 10-bit accumulated sums over a valid/ready handshake, buffers them in a DEPTH-entry FIFO, and presents the per-sample average (sum / 4) as an 8-bit value on a second valid/ready handshake. It decouples the bursty one-in-four output of the accumulator from a consumer that may stall for several cycles.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- valid_a  input  1  upstream sum valid
- data_in  input  10  upstream accumulated sum (unsigned)
- ready_a  output  1  FIFO can accept a sum this cycle
- valid_b  output  1  average available on data_out
- ready_b  input  1  downstream accepts data_out this cycle
- data_out  output  8  average of head entry (unsigned)
- level  output  $clog2(DEPTH)+1  number of entries currently stored

## Operation
- Storage: DEPTH × 10-bit register array, write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH; level counter 0..DEPTH.
- Write: wr_en = valid_a & ready_a; stores data_in at wr_ptr, wr_ptr+1.
- Read: rd_en = valid_b & ready_b; rd_ptr+1.
- ready_a = (level != DEPTH); depends only on registered state, never on ready_b (no combinational ready path through the block).
- valid_b = (level != 0).
- data_out = average of mem[rd_ptr]; combinational from registered head entry; stable while valid_b & ~ready_b.
- Average: 11-bit intermediate; result = intermediate >> 2, saturated to 255 (see Configuration).
- level update: +1 on wr_en only, −1 on rd_en only, unchanged on both or neither.
- Full + ready_b high same cycle: ready_a is still 0 that cycle (no write-through on full); slot becomes available the next cycle.
- Empty + valid_a: write accepted; data not visible on data_out until next cycle (no bypass).
- Data not accepted while ready_a = 0 is not stored; upstream holds it per the handshake rule.
- Data order strictly FIFO; no reordering, no dropping.

## Timing
- Reset (rst_n low, asynchronous): wr_ptr = 0, rd_ptr = 0, level = 0 → ready_a = 1, valid_b = 0, data_out = average of mem[0]; memory contents not reset and don't-care while valid_b = 0. Reset mid-operation discards all stored entries.
- Write-to-output latency: 1 cycle (sum accepted at edge N is on data_out with valid_b = 1 after edge N, when FIFO was empty).
- Throughput: one write and one read per cycle sustained when 0 < level < DEPTH.
- Pointer wrap: DEPTH−1 → 0 with no bubble.
- Handshake rules: upstream must hold valid_a/data_in until ready_a; block holds valid_b/data_out until ready_b; valid_b never drops without a read.

## Configuration
- AVG_FIFO_ROUND_EN defined: round-half-up, intermediate = data_in + 2, result = min(intermediate >> 2, 255). E.g. 6 → 2, 5 → 1, 1023 → 255 (saturated).
- AVG_FIFO_ROUND_EN undefined: truncate, result = data_in >> 2. E.g. 6 → 1, 7 → 1, 1023 → 255. Saturation logic is not generated.
- Macro affects only the data_out arithmetic; handshake and level behaviour identical in both builds.

## Test plan
- Reset then single write data_in = 400, ready_b = 1 → valid_b = 1 one cycle later, data_out = 100, level 1 → 0 after read.
- Fill with ready_b = 0: write 4, 8, 12, 16 (DEPTH = 4) → level = 4, ready_a = 0; 5th valid_a held, not stored; release ready_b → outputs 1, 2, 3, 4 in order, then held 5th entry.
- Simultaneous read/write at level 2 for 10 cycles, incrementing data → level stays 2, output sequence intact across pointer wrap.
- Full with ready_b = 1: ready_a stays 0 that cycle; next cycle ready_a = 1, level = 3.
- Rounding: data_in = 6, 5, 1023 → 2, 1, 255 with AVG_FIFO_ROUND_EN; 1, 1, 255 without.
- Assert rst_n low at level 3 mid-transfer → immediately valid_b = 0, ready_a = 1, level = 0; next write after release appears as sole entry.
